// File: rtl/cdb_arbiter_if.sv
// Result-bus types and the FU-to-arbiter bundle shared by the arbiter and its users.
package cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [5:0]  pd;
        logic [5:0]  rob_tag;
        logic [31:0] data;
    } cdb_entry_t;
endpackage

// Handshake: fu_out[i].valid is the request and the entry is held stable until a
// cycle with fu_grant[i]=1; that cycle is the transfer, and flush/reset suppress it.
interface cdb_arbiter_if #(parameter int NUM_FU = 4) ();
    cdb_pkg::cdb_entry_t fu_out [NUM_FU];
    logic                flush;
    logic [NUM_FU-1:0]   fu_grant;
    cdb_pkg::cdb_entry_t cdb;
    cdb_pkg::cdb_entry_t cdb2;

    modport master (output fu_out, flush, input fu_grant, cdb, cdb2);
    modport slave  (input fu_out, flush, output fu_grant, cdb, cdb2);
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to two FU results per cycle onto the registered
// cdb/cdb2 broadcast buses.
module cdb_arbiter #(
    parameter  int NUM_FU = 4,
    localparam int PTR_W  = $clog2(NUM_FU)
) (
    input  logic             clk,
    input  logic             rst,
    cdb_arbiter_if.slave     bus,
    output logic [PTR_W-1:0] dbg_rr_ptr_o
);
    import cdb_pkg::*;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    cdb_entry_t        cdb_q, cdb_d;
    cdb_entry_t        cdb2_q, cdb2_d;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] grant;
    logic              s0_found, s1_found;
    logic [PTR_W-1:0]  s0_idx, s1_idx;
    logic [PTR_W-1:0]  cand_idx;
    int                cand_sum;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (int'(i) == NUM_FU - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin : req_vec
        req = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            req[i] = bus.fu_out[i].valid;
        end
    end

    // Scan NUM_FU candidates starting at rr_ptr, wrapping modulo NUM_FU.
    always_comb begin : select
        s0_found = 1'b0;
        s1_found = 1'b0;
        s0_idx   = '0;
        s1_idx   = '0;
        cand_sum = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand_sum = int'(rr_ptr_q) + k;
            if (cand_sum >= NUM_FU) begin
                cand_sum = cand_sum - NUM_FU;
            end
            cand_idx = PTR_W'(cand_sum);
            if (req[cand_idx]) begin
                if (!s0_found) begin
                    s0_found = 1'b1;
                    s0_idx   = cand_idx;
                end else if (!s1_found) begin
                    s1_found = 1'b1;
                    s1_idx   = cand_idx;
                end
            end
        end
    end

    always_comb begin : next_state
        grant    = '0;
        cdb_d    = '0;
        cdb2_d   = '0;
        rr_ptr_d = rr_ptr_q;
        if (rst && !bus.flush) begin
            if (s0_found) begin
                grant[s0_idx] = 1'b1;
                cdb_d         = bus.fu_out[s0_idx];
                rr_ptr_d      = next_idx(s0_idx);
            end
            if (s1_found) begin
                grant[s1_idx] = 1'b1;
                cdb2_d        = bus.fu_out[s1_idx];
                rr_ptr_d      = next_idx(s1_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_q.valid  <= 1'b0;
            cdb2_q.valid <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            cdb_q    <= cdb_d;
            cdb2_q   <= cdb2_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.fu_grant = grant;
    assign bus.cdb      = cdb_q;
    assign bus.cdb2     = cdb2_q;
    assign dbg_rr_ptr_o = rr_ptr_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter against a list-based round-robin model.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N     = 4;
    localparam int EW    = $bits(cdb_entry_t);
    localparam int BOUND = ((N - 1) + 1) / 2 + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dbg_ptr;

    cdb_arbiter_if #(.NUM_FU(N)) bus ();

    cdb_arbiter #(.NUM_FU(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .dbg_rr_ptr_o (dbg_ptr)
    );

    always #5 clk = ~clk;

    int               total = 0;
    int               bad   = 0;
    logic [EW-1:0]    exp0_q[$];
    logic [EW-1:0]    exp1_q[$];
    cdb_entry_t       pend [N];
    int               wait_cnt [N];
    int               m_ptr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_slot(input string name, input cdb_entry_t act, input cdb_entry_t exp);
        if (!exp.valid) begin
            check({name, "_valid"}, 64'(act.valid), 64'(1'b0));
        end else begin
            check(name, 64'(act), 64'(exp));
        end
    endtask

    // Model: list the FUs in priority order from the pointer, take the first two requesters.
    task automatic model_step(input logic r, input logic f);
        int         order[$];
        int         win[$];
        logic [N-1:0] exp_grant;
        cdb_entry_t e0, e1;
        exp_grant = '0;
        e0 = '0;
        e1 = '0;
        if (r) begin
            check("rr_ptr", 64'(dbg_ptr), 64'(m_ptr));
        end
        if (r && !f) begin
            for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
            foreach (order[j]) begin
                if (pend[order[j]].valid && win.size() < 2) win.push_back(order[j]);
            end
            foreach (win[j]) exp_grant[win[j]] = 1'b1;
            if (win.size() > 0) e0 = pend[win[0]];
            if (win.size() > 1) e1 = pend[win[1]];
            if (win.size() > 0) m_ptr = (win[win.size() - 1] + 1) % N;
        end
        check("fu_grant", 64'(bus.fu_grant), 64'(exp_grant));
        exp0_q.push_back(e0);
        exp1_q.push_back(e1);
        for (int i = 0; i < N; i++) begin
            if (r && !f && pend[i].valid) begin
                if (exp_grant[i]) begin
                    check($sformatf("fair_fu%0d", i), 64'(wait_cnt[i] + 1 <= BOUND), 64'(1));
                    wait_cnt[i] = 0;
                    pend[i].valid = 1'b0;
                end else begin
                    wait_cnt[i]++;
                end
            end else begin
                wait_cnt[i] = 0;
            end
            if (r && f) pend[i].valid = 1'b0;
        end
        if (!r) m_ptr = 0;
    endtask

    task automatic drive_cycle(input logic r, input logic f, input logic [N-1:0] mask, input int force_pd);
        @(posedge clk);
        #1;
        rst       = r;
        bus.flush = f;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !pend[i].valid) begin
                pend[i].valid   = 1'b1;
                pend[i].pd      = 6'((force_pd < 0) ? $urandom_range(0, 63) : force_pd);
                pend[i].rob_tag = 6'($urandom_range(0, 63));
                pend[i].data    = $urandom;
            end
            bus.fu_out[i] = pend[i];
        end
        @(negedge clk);
        model_step(r, f);
    endtask

    initial begin : monitor
        cdb_entry_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp0_q.size() > 0) begin
                e = exp0_q.pop_front();
                check_slot("cdb", bus.cdb, e);
            end
            if (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                check_slot("cdb2", bus.cdb2, e);
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < N; i++) begin
            pend[i]       = '0;
            wait_cnt[i]   = 0;
            bus.fu_out[i] = '0;
        end
        bus.flush = 1'b0;
        rst       = 1'b0;

        repeat (2) drive_cycle(1'b0, 1'b0, 4'b1111, -1);
        repeat (8) drive_cycle(1'b1, 1'b0, 4'b1111, -1);
        repeat (3) drive_cycle(1'b1, 1'b0, 4'b0000, -1);
        drive_cycle(1'b1, 1'b0, 4'b0100, 7);
        drive_cycle(1'b1, 1'b0, 4'b0000, -1);
        drive_cycle(1'b1, 1'b0, 4'b1001, -1);
        drive_cycle(1'b1, 1'b0, 4'b0000, -1);
        drive_cycle(1'b1, 1'b0, 4'b0101, -1);
        drive_cycle(1'b1, 1'b1, 4'b1010, -1);
        drive_cycle(1'b1, 1'b0, 4'b0000, -1);

        for (int c = 0; c < 300; c++) begin
            drive_cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
                        4'($urandom_range(0, 15)), -1);
        end
        for (int c = 0; c < 40; c++) begin
            drive_cycle(1'b1, 1'b0, {3'($urandom_range(0, 7)), 1'b1}, -1);
        end
        repeat (3) drive_cycle(1'b1, 1'b0, 4'b0000, -1);

        @(posedge clk);
        #5;
        check("leftover", 64'(exp0_q.size() + exp1_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the two common data buses (`cdb`, `cdb2`) among the `NUM_FU` functional-unit result ports (ALU, multiplier, divider, load/store, ...). Each cycle it grants up to two pending results using round-robin priority. It registers the winners onto the buses that the reservation stations, ROB and physical register file snoop. A functional unit holds its result until granted, so the arbiter is the only back-pressure point between execution and writeback.

## Interface
Parameters:
- `NUM_FU`, default 4: number of requesting functional units; minimum 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-low; state clears on a rising edge of `clk` where `rst`=0.
- `fu_out[NUM_FU]` in `cdb_entry_t`: per-FU result; `.valid` is the request.
- `flush` in 1: mispredict flush; suppresses all grants this cycle and clears the buses next cycle.
- `fu_grant` out `NUM_FU`: combinational accept; FU i drops or replaces its result after a cycle with `fu_grant[i]`=1.
- `cdb` out `cdb_entry_t`: registered broadcast, slot 0.
- `cdb2` out `cdb_entry_t`: registered broadcast, slot 1.

## Operation
- State:
  - `rr_ptr` (`$clog2(NUM_FU)` bits): highest-priority FU index.
  - Output registers `cdb` and `cdb2`.
- Selection, combinational each cycle:
  - Scan indices `rr_ptr`, `rr_ptr+1`, ... modulo `NUM_FU`; exactly `NUM_FU` candidates, each checked once.
  - The first index with `fu_out[i].valid` wins slot 0; the second wins slot 1.
  - The remaining requesters get no grant and must hold their results stable.
- `fu_grant[i]`=1 iff i won a slot and `flush`=0. At most two bits are set; never the same FU in both slots.
- Register update (rst=1, flush=0):
  - `cdb <= fu_out[slot0 winner]`, or `cdb.valid <= 0` if there is no winner.
  - `cdb2 <= fu_out[slot1 winner]`, or `cdb2.valid <= 0` if there is no second winner.
  - Only `.valid` is required to be 0 on an idle slot; the other fields are don't-care.
- Pointer update:
  - `rr_ptr <= (last granted index + 1) mod NUM_FU`. The last granted index is slot 1 if it was granted, otherwise slot 0.
  - `rr_ptr` is unchanged if there were no grants.
- Flush (rst=1, flush=1):
  - No grants.
  - `cdb.valid` and `cdb2.valid` are 0 the next cycle.
  - `rr_ptr` is unchanged.
  - FUs are responsible for dropping their own results.
- Reset (rst=0):
  - `cdb.valid`=0, `cdb2.valid`=0, `rr_ptr`=0.
  - `fu_grant` is all-zero during the reset cycle regardless of requests.
  - Reset overrides flush.
- `pd`=0 results are granted and broadcast normally; consumers ignore a destination register of x0.
- Fairness: a continuously requesting FU is granted within `ceil((NUM_FU-1)/2)+1` cycles.

## Timing
- Grant latency: 0 cycles; `fu_grant` is in the same cycle as a qualifying `fu_out.valid`.
- Broadcast latency: 1 cycle; a result granted in cycle N is on `cdb`/`cdb2` in cycle N+1, valid for exactly one cycle.
- Throughput: 2 results per cycle sustained.
- Slot order within a cycle follows round-robin order, not FU index. Consumers treat `cdb` and `cdb2` symmetrically.
- Simultaneous conditions:
  - A `flush` coinciding with pending requests drops them. Outputs already registered in cycle N still broadcast in cycle N+1 only if `flush` was low in cycle N.
  - A request appearing in the same cycle as a wrap of the pointer (`rr_ptr`=`NUM_FU-1`) is scanned in modulo order: index `NUM_FU-1` first, then 0, 1, ...
- No combinational path from `fu_out` to `cdb`/`cdb2`. The only combinational path is `fu_out.valid`/`flush`/`rst` → `fu_grant`.

## Test plan
- **Reset:** hold rst=0 for 2 cycles with all four FUs requesting. Required: `fu_grant`=0000, `cdb.valid`=0, `cdb2.valid`=0. After release, the first grant is 0011 (FU0→cdb, FU1→cdb2) and `rr_ptr`=2.
- **Round-robin under saturation:** NUM_FU=4, all FUs requesting every cycle. Required: the grant sequence is 0011, 1100, 0011, ... and each FU is broadcast once every 2 cycles.
- **Single requester:** only FU2 is valid with pd=7. Required: `fu_grant`=0100; the next cycle has `cdb.pd`=7, `cdb.valid`=1, `cdb2.valid`=0; then `rr_ptr`=3.
- **Wrap-around:** `rr_ptr`=3 with FU3 and FU0 requesting. Required: FU3→`cdb`, FU0→`cdb2`, then `rr_ptr`=1.
- **Flush:** FU1 and FU3 requesting with flush=1. Required: `fu_grant`=0000, both buses invalid the next cycle, `rr_ptr` unchanged. A broadcast already registered from the prior cycle still appears.
- **Hold and fairness:** FU0 requests continuously while FUs 1-3 toggle. Required: FU0 is never starved for more than 2 cycles, and its result fields are unchanged on the bus when it is finally granted.
